fadd_pipe: RTL and testbench

Pipelined, parametrised IEEE-754-style floating-point adder/subtractor with valid/ready handshaking, for the systolic-array accumulation path. It is the successor to the combinational single-precision adder. It adds effective subtraction, leading-zero normalisation, round-to-nearest-even, special-value handling and status flags. A 3-stage pipeline with a global stall lets it sit directly between a PE accumulator and a back-pressuring output buffer.

---
 rtl/fadd_pipe_pkg.sv | 33 +++
 rtl/fadd_pipe_lzc.sv | 24 ++
 rtl/fadd_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_fadd_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_pipe_pkg.sv
// Shared types and constants for the pipelined FP adder.
// Default format is IEEE single precision.
package fadd_pipe_pkg;

  localparam int EXP_W_D = 8;
  localparam int M_W_D   = 23;

  typedef struct packed {
    logic               sign;
    logic [EXP_W_D-1:0] exp;
    logic [M_W_D-1:0]   man;
  } fp_word_t;

  localparam logic [EXP_W_D-1:0] EXP_ALL1 = '1;
  localparam fp_word_t QNAN = '{
    sign: 1'b0,
    exp:  EXP_ALL1,
    man:  {1'b1, {(M_W_D-1){1'b0}}}
  };
  localparam int BIAS = (1 << (EXP_W_D-1)) - 1;

  typedef enum logic [1:0] {
    NORMAL,
    ZERO_PASS,
    INF,
    NAN
  } tag_e;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

endpackage

// File: rtl/fadd_pipe_lzc.sv
// Leading-zero counter, MSB first.
// All-zero input yields W.
module fadd_pipe_lzc #(
  parameter int W  = 28,
  parameter int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  x,
  output logic [CW-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = CW'(W);
    found = 1'b0;
    for (int i = W-1; i >= 0; i--) begin
      if (!found && x[i]) begin
        cnt   = CW'(W-1-i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// 3-stage FP adder/subtractor: align, add, normalise/round.
// One global stall moves all stages together.
module fadd_pipe
  import fadd_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int M_W   = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+M_W:0]   a,
  input  logic [EXP_W+M_W:0]   b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+M_W:0]   result,
  output logic [2:0]           flags
);

  localparam int W      = 1+EXP_W+M_W;
  localparam int SW     = M_W+4;
  localparam int NW     = M_W+5;
  localparam int CW     = $clog2(NW+1);
  localparam int SH_MAX = M_W+3;
  localparam logic [EXP_W-1:0] E1 = '1;
  localparam logic [W-1:0] QN =
    {1'b0, E1, 1'b1, {(M_W-1){1'b0}}};

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [M_W-1:0]   ma, mb;
  logic             za, zb, ia, ib, na, nb;
  logic [W-1:0]     bn;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ op;
  assign ea = a[W-2:M_W];
  assign eb = b[W-2:M_W];
  assign ma = a[M_W-1:0];
  assign mb = b[M_W-1:0];
  assign bn = {sb, b[W-2:0]};

  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == E1) && (ma == '0);
  assign ib = (eb == E1) && (mb == '0);
  assign na = (ea == E1) && (ma != '0);
  assign nb = (eb == E1) && (mb != '0);

  tag_e         c_tag;
  logic [W-1:0] c_byp;

  always_comb begin
    c_tag = NORMAL;
    c_byp = '0;
    if (na | nb | (ia & ib & (sa ^ sb))) begin
      c_tag = NAN;
      c_byp = QN;
    end else if (ia) begin
      c_tag = INF;
      c_byp = a;
    end else if (ib) begin
      c_tag = INF;
      c_byp = bn;
    end else if (za & zb) begin
      c_tag = ZERO_PASS;
      c_byp = {sa & sb, {(W-1){1'b0}}};
    end else if (za) begin
      c_tag = ZERO_PASS;
      c_byp = bn;
    end else if (zb) begin
      c_tag = ZERO_PASS;
      c_byp = a;
    end
  end

  logic             a_ge, sh_sign;
  logic [EXP_W-1:0] eh, el;
  logic [M_W-1:0]   mh, ml;
  logic [EXP_W:0]   diff, sh;
  logic [SW-1:0]    sig_h, sig_l;
  logic [SW-1:0]    mask, l_shr, sig_al;

  assign a_ge    = {ea, ma} >= {eb, mb};
  assign eh      = a_ge ? ea : eb;
  assign el      = a_ge ? eb : ea;
  assign mh      = a_ge ? ma : mb;
  assign ml      = a_ge ? mb : ma;
  assign sh_sign = a_ge ? sa : sb;

  // Saturating the shift keeps huge exponent gaps as pure sticky.
  assign diff = {1'b0, eh} - {1'b0, el};
  assign sh   = (diff > (EXP_W+1)'(SH_MAX)) ?
                (EXP_W+1)'(SH_MAX) : diff;

  assign sig_h  = {1'b1, mh, 3'b000};
  assign sig_l  = {1'b1, ml, 3'b000};
  assign mask   = (SW'(1) << sh) - SW'(1);
  assign l_shr  = sig_l >> sh;
  assign sig_al = {l_shr[SW-1:1],
                   l_shr[0] | (|(sig_l & mask))};

  logic             s1_v, s1_sign, s1_sub;
  tag_e             s1_tag;
  logic [W-1:0]     s1_byp;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_sh, s1_sl;

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_tag  <= c_tag;
      s1_byp  <= c_byp;
      s1_sign <= sh_sign;
      s1_sub  <= sa ^ sb;
      s1_exp  <= eh;
      s1_sh   <= sig_h;
      s1_sl   <= sig_al;
    end
  end

  logic [NW-1:0] sum;
  logic [CW-1:0] lz;

  assign sum = s1_sub ?
    {1'b0, s1_sh} - {1'b0, s1_sl} :
    {1'b0, s1_sh} + {1'b0, s1_sl};

  fadd_pipe_lzc #(.W(NW), .CW(CW)) u_lzc (
    .x   (sum),
    .cnt (lz)
  );

  logic             s2_v, s2_sign;
  tag_e             s2_tag;
  logic [W-1:0]     s2_byp;
  logic [EXP_W-1:0] s2_exp;
  logic [NW-1:0]    s2_sum;
  logic [CW-1:0]    s2_lz;

  always_ff @(posedge clk) begin
    if (advance) begin
      s2_tag  <= s1_tag;
      s2_byp  <= s1_byp;
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_sum  <= sum;
      s2_lz   <= lz;
    end
  end

  // Shifting by lz puts the leading one at the carry slot;
  // the carry case (lz=0) then folds its lsb into sticky.
  logic [NW-1:0]    nsh;
  logic [SW-1:0]    norm;
  logic [M_W:0]     mant;
  logic             g, r, s, inex, rnd_up;
  logic [M_W+1:0]   mant_r;
  logic [M_W-1:0]   man_f;
  logic [EXP_W+1:0] exp_n, exp_f;
  logic             flush, ovf;

  assign nsh    = s2_sum << s2_lz;
  assign norm   = {nsh[NW-1:2], nsh[1] | nsh[0]};
  assign mant   = norm[SW-1:3];
  assign g      = norm[2];
  assign r      = norm[1];
  assign s      = norm[0];
  assign inex   = g | r | s;
  assign rnd_up = g & (r | s | mant[0]);
  assign mant_r = {1'b0, mant} + (M_W+2)'(rnd_up);
  assign man_f  = mant_r[M_W+1] ?
                  mant_r[M_W:1] : mant_r[M_W-1:0];

  assign exp_n = {2'b00, s2_exp} + (EXP_W+2)'(1)
               - (EXP_W+2)'(s2_lz);
  assign exp_f = exp_n + (EXP_W+2)'(mant_r[M_W+1]);
  assign flush = exp_n[EXP_W+1] | (exp_n == '0);
  assign ovf   = exp_f >= {2'b00, E1};

  logic [W-1:0] r_res;
  logic [2:0]   r_flg;

  always_comb begin
    r_res = s2_byp;
    r_flg = '0;
    unique case (s2_tag)
      NORMAL: begin
        if (s2_sum == '0) begin
          r_res = '0;
        end else if (flush) begin
          r_res = {s2_sign, {(W-1){1'b0}}};
          r_flg[FLAG_INEXACT] = inex;
        end else if (ovf) begin
          r_res = {s2_sign, E1, {M_W{1'b0}}};
          r_flg[FLAG_OVERFLOW] = 1'b1;
          r_flg[FLAG_INEXACT]  = 1'b1;
        end else begin
          r_res = {s2_sign, exp_f[EXP_W-1:0], man_f};
          r_flg[FLAG_INEXACT] = inex;
        end
      end
      NAN:     r_flg[FLAG_INVALID] = 1'b1;
      default: r_flg = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      out_valid <= s2_v;
      if (s2_v) begin
        result <= r_res;
        flags  <= r_flg;
      end
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Randomised and directed bench for fadd_pipe with an
// exact-integer reference model.
module tb_fadd_pipe;
  import fadd_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  fadd_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  int checks = 0;
  int failures = 0;
  logic [34:0] expq[$];

  logic [31:0] sp [8] = '{
    32'h00000000, 32'h80000000, 32'h7F800000,
    32'hFF800000, 32'h7FC00001, 32'h00000005,
    32'h7F7FFFFF, 32'h3F800000
  };

  task automatic check(input string tag,
                       input logic [35:0] got,
                       input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact sum in a wide integer, then RNE to 24 bits.
  function automatic logic [34:0] ref_add(
    input logic [31:0] ai,
    input logic [31:0] bi,
    input logic        opi);
    fp_word_t x, y, hi, lo;
    logic [127:0] v, rem, half, q;
    int d, el, e, p, k;
    logic inex, sub;
    x = ai;
    y = bi;
    y.sign = bi[31] ^ opi;
    if ((x.exp == 8'hFF && x.man != 0) ||
        (y.exp == 8'hFF && y.man != 0) ||
        (x.exp == 8'hFF && y.exp == 8'hFF &&
         x.sign != y.sign))
      return {3'b100, 32'h7FC00000};
    if (x.exp == 8'hFF) return {3'b000, ai};
    if (y.exp == 8'hFF) return {3'b000, y.sign, bi[30:0]};
    if (x.exp == 0 && y.exp == 0)
      return {3'b000, x.sign & y.sign, 31'd0};
    if (x.exp == 0) return {3'b000, y.sign, bi[30:0]};
    if (y.exp == 0) return {3'b000, ai};
    if ({x.exp, x.man} >= {y.exp, y.man}) begin
      hi = x; lo = y;
    end else begin
      hi = y; lo = x;
    end
    sub = hi.sign != lo.sign;
    d = int'(hi.exp) - int'(lo.exp);
    if (d > 60) begin
      v  = {105'd1, hi.man} << 60;
      el = int'(hi.exp) - 60;
      v  = sub ? v - 128'd1 : v + 128'd1;
    end else begin
      v  = {105'd1, hi.man} << d;
      el = int'(lo.exp);
      v  = sub ? v - {105'd1, lo.man} : v + {105'd1, lo.man};
    end
    if (v == 0) return 35'd0;
    p = 0;
    for (int i = 0; i < 128; i++) if (v[i]) p = i;
    e = el + p - 23;
    inex = 1'b0;
    if (p > 23) begin
      k    = p - 23;
      rem  = v & ((128'd1 << k) - 128'd1);
      half = 128'd1 << (k - 1);
      q    = v >> k;
      inex = rem != 0;
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = v << (23 - p);
    end
    if (e <= 0) return {2'b00, inex, hi.sign, 31'd0};
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {3'b011, hi.sign, 8'hFF, 23'd0};
    return {2'b00, inex, hi.sign, 8'(e), q[22:0]};
  endfunction

  task automatic gen(output logic [31:0] ga,
                     output logic [31:0] gb,
                     output logic gop);
    int mode, e1, e2;
    logic [22:0] m1, m2;
    mode = int'($urandom_range(9));
    gop  = 1'($urandom_range(1));
    m1 = 23'($urandom);
    m2 = (mode == 4) ? m1 : 23'($urandom);
    if (mode == 0) begin
      ga = $urandom;
      gb = $urandom;
    end else if (mode == 1) begin
      ga = sp[$urandom_range(7)];
      gb = sp[$urandom_range(7)];
    end else begin
      e1 = (mode == 2) ? int'($urandom_range(254, 245))
                       : int'($urandom_range(140, 100));
      if (mode == 3) e2 = e1 - int'($urandom_range(40));
      else e2 = e1 + int'($urandom_range(6)) - 3;
      if (e2 < 1) e2 = 1;
      if (e2 > 254) e2 = 254;
      ga = {1'($urandom_range(1)), 8'(e1), m1};
      gb = {1'($urandom_range(1)), 8'(e2), m2};
    end
  endtask

  task automatic directed(input string tag,
                          input logic [31:0] da,
                          input logic [31:0] db,
                          input logic dop,
                          input logic [31:0] er,
                          input logic [2:0] ef);
    int k;
    @(negedge clk);
    a = da; b = db; op = dop;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 36'(k), 36'd3);
    check(tag, {flags, result}, {ef, er});
  endtask

  task automatic stream(input int n, input int st_at,
                        input int st_len, input bit rnd);
    int sent, got, cyc;
    bit stp;
    logic [34:0] held;
    sent = 0; got = 0; cyc = 0; stp = 0;
    held = '0;
    while (got < n && cyc < n*8 + 50) begin
      @(negedge clk);
      if (cyc >= st_at && cyc < st_at + st_len)
        out_ready = 1'b0;
      else
        out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (sent < n && (!rnd || $urandom_range(3) != 0)) begin
        gen(a, b, op);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stp)
        check("stall_hold", {out_valid, flags, result},
              {1'b1, held});
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 36'(in_ready), 36'd0);
        held = {flags, result};
        stp = 1;
      end else begin
        stp = 0;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0)
          check("spurious_out", 36'd1, 36'd0);
        else
          check("stream_res", {flags, result}, expq.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_add(a, b, op));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 36'(got), 36'(n));
    repeat (3) begin
      @(negedge clk);
      check("no_dup", 36'(out_valid), 36'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 36'(out_valid), 36'd0);
    check("rst_result", 36'(result), 36'd0);
    check("rst_flags", 36'(flags), 36'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 36'(in_ready), 36'd1);

    directed("add_1_2", 32'h3F800000, 32'h40000000, 1'b0,
             32'h40400000, 3'b000);
    directed("cancel", 32'h3F800000, 32'h3F800000, 1'b1,
             32'h00000000, 3'b000);
    directed("sub_3_1", 32'h40400000, 32'h3F800000, 1'b1,
             32'h40000000, 3'b000);
    directed("tie_even", 32'h3F800000, 32'h33800000, 1'b0,
             32'h3F800000, 3'b001);
    directed("round_up", 32'h3F800001, 32'h33800000, 1'b0,
             32'h3F800002, 3'b001);
    directed("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0,
             32'h7F800000, 3'b011);
    directed("inf_m_inf", 32'h7F800000, 32'hFF800000, 1'b0,
             32'h7FC00000, 3'b100);
    directed("denorm", 32'h00000001, 32'h3F800000, 1'b0,
             32'h3F800000, 3'b000);
    directed("negz_negz", 32'h80000000, 32'h00000000, 1'b1,
             32'h80000000, 3'b000);

    stream(8, 5, 4, 1'b0);
    stream(300, -1, 0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      gen(a, b, op);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight_valid", 36'(out_valid), 36'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 36'(out_valid), 36'd0);
    check("midrst_result", 36'(result), 36'd0);
    check("midrst_flags", 36'(flags), 36'd0);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_ready", 36'(in_ready), 36'd1);
    directed("post_rst", 32'h40400000, 32'h3F800000, 1'b1,
             32'h40000000, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
